prog_loader: RTL
================

# prog_loader

Boot-time program loader that sits between an external byte-stream source (UART or debug-link receiver) and the core's instruction memory write port. It holds the MIPS core in reset, receives a framed program image, assembles big-endian 32-bit words, and writes them sequentially from word address 0. After a trailing XOR checksum verifies, it releases the core; on any framing or checksum failure, it keeps the core in reset and flags an error.

## Interface
- `ADDR_WIDTH`, default 20: instruction-memory word-address width; matches the program memory depth.
- `i_clk` in 1: clock; all logic is on the rising edge.
- `i_rst` in 1: synchronous, active-high reset.
- `i_start` in 1: restart request; honoured only in DONE or ERR.
- `i_rx_data` in 8: stream byte.
- `i_rx_valid` in 1: `i_rx_data` is valid.
- `o_rx_ready` out 1: loader accepts a byte this cycle.
- `o_we` out 1: instruction-memory write strobe, one cycle per word.
- `o_waddr` out ADDR_WIDTH: word address.
- `o_wdata` out 32: instruction word.
- `o_core_rst_n` out 1: active-low reset to the core; high only in DONE.
- `o_done` out 1: image loaded and verified.
- `o_err` out 1: load failed.
- `o_words_loaded` out ADDR_WIDTH+1: count of words written since the last (re)start.

## Operation
- **Frame format:** 4-byte word count N (big-endian), then N×4 data bytes, then a 4-byte checksum. The checksum is the XOR of all N data words; the header is excluded.
- **Byte transfer:** a byte transfers when `i_rx_valid & o_rx_ready` at a clock edge.
- **Word assembly:** the first byte of each word goes to [31:24], the fourth to [7:0].
- **States:**
  - HDR: collect 4 header bytes.
    - N > 2^ADDR_WIDTH → ERR.
    - N == 0 → CSUM.
    - Otherwise → DATA.
  - DATA: collect words and write each one. After word N has been accepted → CSUM.
  - CSUM: collect 4 bytes.
    - Equal to the running XOR → DONE.
    - Otherwise → ERR.
  - DONE: `o_done`=1, `o_core_rst_n`=1. `i_start` → HDR.
  - ERR: `o_err`=1, `o_core_rst_n`=0. `i_start` → HDR.
- **Readiness:** `o_rx_ready`=1 in HDR, DATA and CSUM; 0 in DONE and ERR. Writes never stall the stream.
- **Restart:** clears the byte counter, word index, running XOR and `o_words_loaded`. Memory contents are not cleared.
- **Ignored inputs:** `i_start` is ignored in HDR, DATA and CSUM. `i_rx_valid` is ignored while `o_rx_ready`=0.
- **Counter widths:** the word count is held in 32 bits for the range check. The word index counts 0..N-1 in ADDR_WIDTH bits; it never wraps because N ≤ 2^ADDR_WIDTH is enforced.

## Timing
- **Reset values:**
  - State: HDR.
  - `o_we`=0, `o_waddr`=0, `o_wdata`=0.
  - `o_core_rst_n`=0, `o_done`=0, `o_err`=0, `o_words_loaded`=0.
  - `o_rx_ready`=1 from the first cycle after reset.
- **Write latency:** the 4th byte of data word k is accepted at edge t. Then `o_we`=1 with `o_waddr`=k and the word on `o_wdata` during cycle t+1, for exactly one cycle. `o_words_loaded` increments at edge t+1.
- **Outputs after CSUM:** the last checksum byte is accepted at edge t. From cycle t+1, either `o_done`=1 and `o_core_rst_n`=1, or `o_err`=1. In both cases `o_rx_ready`=0 from t+1.
- **Oversize header:** detected on the 4th header byte at edge t. ERR is entered at t+1 and no write occurs.
- **Restart timing:** `i_start` sampled at edge t in DONE/ERR. State is HDR from t+1; `o_core_rst_n`=0, `o_done`/`o_err`=0 and `o_rx_ready`=1, all from t+1.
- **Reset mid-load:** `i_rst` at edge t takes priority over everything. Any pending write for cycle t+1 is suppressed.
- **Back-pressure:** idle cycles on `i_rx_valid` have no effect on the result.

## Structure
- **Package `loader_pkg`:**
  - State enum {HDR, DATA, CSUM, DONE, ERR}.
  - `HDR_BYTES`=4, `CSUM_BYTES`=4, `BYTES_PER_WORD`=4.
- **Sub-module `word_assembler`:** a 2-bit byte counter and a 32-bit shift register. It takes byte/valid and a clear input, and emits a one-cycle `word_valid` with the assembled word. It is reused for header, data and checksum words.
- **Top level:** FSM, word index, running XOR, range check and output registers.

## Test plan
1. **Good load:** stream N=2, words 0x20080005 and 0x01094020, checksum 0x21014025 → expected response:
   - Writes (0, 0x20080005) then (1, 0x01094020).
   - `o_done`=1, `o_core_rst_n`=1, `o_words_loaded`=2.
   - `o_rx_ready`=0 afterwards.
2. **Bad checksum:** same frame with checksum 0x00000000 → both writes still occur; `o_err`=1, `o_core_rst_n` stays 0.
3. **Empty image:** N=0, checksum 0 → DONE with no `o_we` pulse. Separately, with ADDR_WIDTH=4, N=17 → ERR one cycle after the 4th header byte, no writes.
4. **Back-pressure:** repeat test 1 with `i_rx_valid` high only every third cycle → identical writes and final state; each `o_we` lasts exactly one cycle.
5. **Reset mid-load:** assert `i_rst` after 6 bytes of test 1 → all outputs at reset values; resending the full test 1 frame passes.
6. **Restart:** from DONE, pulse `i_start` → `o_core_rst_n`=0 next cycle; a new frame (N=1, word 0xDEADBEEF, checksum 0xDEADBEEF) writes address 0 and reaches DONE.

Source files
------------

// File: rtl/prog_loader_pkg.sv
// Shared definitions for the boot-time program loader.
//
// Contents:
//   loader_state_e  - loader FSM states
//   HDR_BYTES, CSUM_BYTES, BYTES_PER_WORD - frame geometry
//   count_too_big() - range check of a header word count against the
//                     instruction memory depth (2**aw words)
package loader_pkg;

  typedef enum logic [2:0] {
    HDR  = 3'd0,
    DATA = 3'd1,
    CSUM = 3'd2,
    DONE = 3'd3,
    ERR  = 3'd4
  } loader_state_e;

  localparam int HDR_BYTES      = 4;
  localparam int CSUM_BYTES     = 4;
  localparam int BYTES_PER_WORD = 4;

  // A count of exactly 2**aw fills the memory and is allowed. The compare
  // is done in 33 bits so the limit itself is representable.
  function automatic logic count_too_big(input logic [31:0] n, input int unsigned aw);
    logic [32:0] limit;
    limit = 33'd1 << aw;
    return ({1'b0, n} > limit);
  endfunction

endpackage

// File: rtl/prog_loader_if.sv
// Stream-in / memory-write-out bundle of the program loader.
//
// Signals:
//   i_rx_data  [7:0]            - stream byte
//   i_rx_valid                  - stream byte valid
//   o_rx_ready                  - loader accepts a byte this cycle
//   o_we                        - instruction memory write strobe
//   o_waddr    [ADDR_WIDTH-1:0] - instruction memory word address
//   o_wdata    [31:0]           - instruction word
//
// Modports:
//   master - the loader (consumes the stream, drives the write port)
//   slave  - the environment (byte source and instruction memory)
interface prog_loader_if #(
  parameter int ADDR_WIDTH = 20
);

  logic [7:0]            i_rx_data;
  logic                  i_rx_valid;
  logic                  o_rx_ready;
  logic                  o_we;
  logic [ADDR_WIDTH-1:0] o_waddr;
  logic [31:0]           o_wdata;

  modport master (
    input  i_rx_data,
    input  i_rx_valid,
    output o_rx_ready,
    output o_we,
    output o_waddr,
    output o_wdata
  );

  modport slave (
    output i_rx_data,
    output i_rx_valid,
    input  o_rx_ready,
    input  o_we,
    input  o_waddr,
    input  o_wdata
  );

endinterface

// File: rtl/prog_loader_word_assembler.sv
// Big-endian byte-to-word assembler shared by header, data and checksum
// phases of the loader.
//
// Ports:
//   i_clk, i_rst   - clock, synchronous active-high reset
//   i_clear        - drop any partially assembled word
//   i_valid        - i_byte is transferred this cycle
//   i_byte [7:0]   - incoming byte, first byte of a word is the MSB
//   o_word_valid   - the byte on i_byte completes a word (one cycle)
//   o_word [31:0]  - assembled word, valid with o_word_valid
//
// The completed word is presented combinationally in the same cycle as its
// last byte, so the caller can act on it at the very edge that accepts that
// byte. Only the first three bytes need storing.
module word_assembler
  import loader_pkg::*;
(
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_clear,
  input  logic        i_valid,
  input  logic [7:0]  i_byte,
  output logic        o_word_valid,
  output logic [31:0] o_word
);

  localparam logic [1:0] LAST_BYTE = 2'(BYTES_PER_WORD - 1);

  logic [1:0]  byte_cnt_reg;
  logic [23:0] shift_reg;

  always_ff @(posedge i_clk) begin
    if (i_rst || i_clear) begin
      byte_cnt_reg <= '0;
      shift_reg    <= '0;
    end else if (i_valid) begin
      // Counter wraps to 0 after the fourth byte; stale shift contents are
      // pushed out by the next word's first three bytes.
      byte_cnt_reg <= byte_cnt_reg + 2'd1;
      shift_reg    <= {shift_reg[15:0], i_byte};
    end
  end

  assign o_word_valid = i_valid && (byte_cnt_reg == LAST_BYTE);
  assign o_word       = {shift_reg, i_byte};

endmodule

// File: rtl/prog_loader.sv
// Boot-time program loader.
//
// Holds the core in reset, receives a framed image
//   [N (4 bytes BE)] [N x 32-bit words BE] [XOR of data words (4 bytes BE)]
// writes the words to instruction memory from word address 0, and releases
// the core only after the checksum matches.
//
// Ports:
//   i_clk, i_rst         - clock, synchronous active-high reset
//   i_start              - restart request, honoured in DONE/ERR only
//   bus (master)         - byte stream in, instruction memory write out
//   o_core_rst_n         - active-low core reset, high only in DONE
//   o_done               - image loaded and verified
//   o_err                - framing/checksum failure
//   o_words_loaded       - words written since the last (re)start
module prog_loader
  import loader_pkg::*;
#(
  parameter int ADDR_WIDTH = 20
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_start,
  prog_loader_if.master         bus,
  output logic                  o_core_rst_n,
  output logic                  o_done,
  output logic                  o_err,
  output logic [ADDR_WIDTH:0]   o_words_loaded
);

  loader_state_e         state_reg, state_next;
  logic [31:0]           word_count_reg, word_count_next;
  logic [ADDR_WIDTH-1:0] word_idx_reg, word_idx_next;
  logic [31:0]           xor_reg, xor_next;
  logic                  we_reg, we_next;
  logic [ADDR_WIDTH-1:0] waddr_reg, waddr_next;
  logic [31:0]           wdata_reg, wdata_next;
  logic [ADDR_WIDTH:0]   words_loaded_reg, words_loaded_next;

  logic        rx_ready;
  logic        rx_accept;
  logic        asm_clear;
  logic        word_valid;
  logic [31:0] word;
  logic        last_word;

  assign rx_ready  = (state_reg == HDR) || (state_reg == DATA) || (state_reg == CSUM);
  assign rx_accept = bus.i_rx_valid && rx_ready;

  word_assembler u_word_assembler (
    .i_clk        (i_clk),
    .i_rst        (i_rst),
    .i_clear      (asm_clear),
    .i_valid      (rx_accept),
    .i_byte       (bus.i_rx_data),
    .o_word_valid (word_valid),
    .o_word       (word)
  );

  // Index N-1 is the final data word. Widened so N == 2**ADDR_WIDTH works.
  assign last_word = ((33'(word_idx_reg) + 33'd1) == {1'b0, word_count_reg});

  always_comb begin
    state_next        = state_reg;
    word_count_next   = word_count_reg;
    word_idx_next     = word_idx_reg;
    xor_next          = xor_reg;
    we_next           = 1'b0;
    waddr_next        = waddr_reg;
    wdata_next        = wdata_reg;
    // The count follows the write strobe, one edge after the word is taken.
    words_loaded_next = words_loaded_reg + {{ADDR_WIDTH{1'b0}}, we_reg};
    asm_clear         = 1'b0;

    case (state_reg)
      HDR: begin
        if (word_valid) begin
          word_count_next = word;
          if (count_too_big(word, ADDR_WIDTH)) begin
            state_next = ERR;
          end else if (word == 32'd0) begin
            state_next = CSUM;
          end else begin
            state_next = DATA;
          end
        end
      end

      DATA: begin
        if (word_valid) begin
          we_next    = 1'b1;
          waddr_next = word_idx_reg;
          wdata_next = word;
          xor_next   = xor_reg ^ word;
          if (last_word) begin
            // Index is left at N-1 so it never wraps for a full memory.
            state_next = CSUM;
          end else begin
            word_idx_next = word_idx_reg + 1'b1;
          end
        end
      end

      CSUM: begin
        if (word_valid) begin
          state_next = (word == xor_reg) ? DONE : ERR;
        end
      end

      DONE, ERR: begin
        if (i_start) begin
          state_next        = HDR;
          word_count_next   = '0;
          word_idx_next     = '0;
          xor_next          = '0;
          words_loaded_next = '0;
          asm_clear         = 1'b1;
        end
      end

      default: begin
        state_next = HDR;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_reg        <= HDR;
      word_count_reg   <= '0;
      word_idx_reg     <= '0;
      xor_reg          <= '0;
      we_reg           <= 1'b0;
      waddr_reg        <= '0;
      wdata_reg        <= '0;
      words_loaded_reg <= '0;
    end else begin
      state_reg        <= state_next;
      word_count_reg   <= word_count_next;
      word_idx_reg     <= word_idx_next;
      xor_reg          <= xor_next;
      we_reg           <= we_next;
      waddr_reg        <= waddr_next;
      wdata_reg        <= wdata_next;
      words_loaded_reg <= words_loaded_next;
    end
  end

  assign bus.o_rx_ready = rx_ready;
  assign bus.o_we       = we_reg;
  assign bus.o_waddr    = waddr_reg;
  assign bus.o_wdata    = wdata_reg;

  assign o_core_rst_n   = (state_reg == DONE);
  assign o_done         = (state_reg == DONE);
  assign o_err          = (state_reg == ERR);
  assign o_words_loaded = words_loaded_reg;

endmodule
